// File: rtl/rhythm_judge_scorer_pkg.sv
// Shared encodings and constants for the rhythm-game judge/scorer.
// Judgement codes match the judge_result wire format seen by the display logic.
package rhythm_judge_scorer_pkg;

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'b00,
    JUDGE_PERFECT = 2'b01,
    JUDGE_GOOD    = 2'b10,
    JUDGE_MISS    = 2'b11
  } judge_t;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_OPEN = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_t;

  localparam int SCORE_MAX = 99999;
  localparam int COMBO_MAX = 9;
  localparam int ACC_MAX   = 99;
  localparam int DIV_STEPS = 24;

  // Tens digit found by compare/subtract from the top down; input is already <= 99.
  function automatic logic [7:0] bin_to_bcd99(input logic [6:0] value);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = '0;
    rem  = value;
    for (int k = 9; k >= 1; k--) begin
      if (tens == 4'd0 && rem >= 7'(k * 10)) begin
        tens = 4'(k);
        rem  = rem - 7'(k * 10);
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/rhythm_judge_scorer_acc_divider.sv
// Accuracy divider: 24-step restoring division, quotient clamped to 99 and
// presented as two BCD digits. A zero divisor yields 00 immediately.
module acc_divider
  import rhythm_judge_scorer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [7:0]  bcd
);

  logic [15:0] rem_q;
  logic [15:0] div_q;
  logic [23:0] quo_q;
  logic [4:0]  steps_left;

  logic [16:0] shifted;
  logic        fits;
  logic [15:0] rem_next;
  logic [23:0] quo_next;
  logic [6:0]  quo_clamped;

  // NOTE: every variable driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    shifted     = {rem_q, quo_q[23]};
    fits        = (shifted >= {1'b0, div_q});
    rem_next    = fits ? 16'(shifted - {1'b0, div_q}) : shifted[15:0];
    quo_next    = {quo_q[22:0], fits};
    quo_clamped = (quo_next > 24'(ACC_MAX)) ? 7'(ACC_MAX) : quo_next[6:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (divisor == '0) begin
          bcd  <= '0;
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          busy       <= 1'b1;
          rem_q      <= '0;
          quo_q      <= dividend;
          div_q      <= divisor;
          steps_left <= 5'(DIV_STEPS);
        end
      end else if (busy) begin
        rem_q      <= rem_next;
        quo_q      <= quo_next;
        steps_left <= steps_left - 5'd1;
        // The last iteration's quotient is converted on the same edge it is produced.
        if (steps_left == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= bin_to_bcd99(quo_clamped);
        end
      end
    end
  end

endmodule

// File: rtl/rhythm_judge_scorer.sv
// Judges per-lane key presses against note arrivals and accumulates score,
// combo and BCD accuracy for the display. One judgement is reported per cycle.
module rhythm_judge_scorer #(
  parameter int LANES       = 4,
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 6,
  parameter int PTS_PERFECT = 100,
  parameter int PTS_GOOD    = 50,
  parameter int SCORE_MAX   = rhythm_judge_scorer_pkg::SCORE_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_start,
  input  logic             tick,
  input  logic [LANES-1:0] note_valid,
  input  logic [LANES-1:0] key_press,
  output logic [31:0]      score,
  output logic [3:0]       combo,
  output logic [7:0]       accuracy,
  output logic             judge_valid,
  output logic [2:0]       judge_lane,
  output logic [1:0]       judge_result,
  output logic             overrun
);
  import rhythm_judge_scorer_pkg::*;

  localparam int AGE_W = $clog2(WIN_GOOD + 2);

  logic clear;
  assign clear = rst | game_start;

  lane_state_t      lane_state  [LANES];
  logic [AGE_W-1:0] lane_age    [LANES];
  judge_t           lane_result [LANES];

  logic             grant_any;
  logic [2:0]       grant_idx;
  judge_t           grant_result;
  logic [LANES-1:0] lane_grant;
  logic             drop_note;
  logic [31:0]      pts;

  logic [15:0] note_count;
  logic [15:0] hit_count;

  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic        acc_pending;
  logic [23:0] dividend;

  // Fixed priority: the loop runs high to low so the lowest DONE lane is the last to win.
  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_result = JUDGE_NONE;
    lane_grant   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_state[i] == LANE_DONE) begin
        grant_any     = 1'b1;
        grant_idx     = 3'(i);
        grant_result  = lane_result[i];
        lane_grant    = '0;
        lane_grant[i] = 1'b1;
      end
    end
  end

  // A note is lost when its lane still holds an open note or an unserved result.
  always_comb begin
    drop_note = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (note_valid[i] &&
          (lane_state[i] == LANE_OPEN ||
           (lane_state[i] == LANE_DONE && !lane_grant[i]))) begin
        drop_note = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < LANES; i++) begin
        lane_state[i]  <= LANE_IDLE;
        lane_age[i]    <= '0;
        lane_result[i] <= JUDGE_NONE;
      end
      overrun <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        case (lane_state[i])
          LANE_IDLE: begin
            if (note_valid[i]) begin
              lane_state[i] <= LANE_OPEN;
              lane_age[i]   <= '0;
            end
          end
          LANE_OPEN: begin
            // Key beats both a colliding note and the expiring tick.
            if (key_press[i]) begin
              lane_state[i]  <= LANE_DONE;
              lane_result[i] <= (lane_age[i] <= AGE_W'(WIN_PERFECT)) ? JUDGE_PERFECT : JUDGE_GOOD;
            end else if (note_valid[i]) begin
              lane_state[i]  <= LANE_DONE;
              lane_result[i] <= JUDGE_MISS;
            end else if (tick) begin
              if (lane_age[i] >= AGE_W'(WIN_GOOD)) begin
                lane_state[i]  <= LANE_DONE;
                lane_result[i] <= JUDGE_MISS;
              end else begin
                lane_age[i] <= lane_age[i] + 1'b1;
              end
            end
          end
          LANE_DONE: begin
            if (lane_grant[i]) begin
              lane_state[i] <= note_valid[i] ? LANE_OPEN : LANE_IDLE;
              lane_age[i]   <= '0;
            end
          end
          default: lane_state[i] <= LANE_IDLE;
        endcase
      end
      if (drop_note) begin
        overrun <= 1'b1;
      end
    end
  end

  assign pts = (grant_result == JUDGE_PERFECT) ? 32'(PTS_PERFECT) : 32'(PTS_GOOD);

  always_ff @(posedge clk) begin
    if (clear) begin
      score        <= '0;
      combo        <= '0;
      judge_valid  <= 1'b0;
      judge_lane   <= '0;
      judge_result <= '0;
      note_count   <= '0;
      hit_count    <= '0;
    end else begin
      judge_valid <= grant_any;
      if (grant_any) begin
        judge_lane   <= grant_idx;
        judge_result <= grant_result;
        if (note_count != 16'hFFFF) begin
          note_count <= note_count + 16'd1;
        end
        if (grant_result != JUDGE_MISS) begin
          if (hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
          end
          combo <= (combo >= 4'(COMBO_MAX)) ? 4'(COMBO_MAX) : combo + 4'd1;
          if (score > 32'(SCORE_MAX) - pts) begin
            score <= 32'(SCORE_MAX);
          end else begin
            score <= score + pts;
          end
        end else begin
          combo <= '0;
        end
      end
    end
  end

  // Grants arriving while a division runs collapse into one rerun with the latest counters.
  assign div_start = !div_busy && !div_done && (judge_valid || acc_pending);
  assign dividend  = 24'(hit_count) * 24'd100;

  always_ff @(posedge clk) begin
    if (clear) begin
      acc_pending <= 1'b0;
    end else begin
      acc_pending <= (acc_pending || judge_valid) && !div_start;
    end
  end

  acc_divider u_acc_divider (
    .clk      (clk),
    .rst      (clear),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (note_count),
    .busy     (div_busy),
    .done     (div_done),
    .bcd      (accuracy)
  );

endmodule

// File: tb/tb_rhythm_judge_scorer.sv
// Directed scenarios followed by a randomized run checked against a lane-level
// reference model; prints one TB_RESULT summary line.
module tb_rhythm_judge_scorer;

  localparam int LANES = 4;
  localparam int WP    = 2;
  localparam int WG    = 6;
  localparam int PP    = 100;
  localparam int PG    = 50;
  localparam int SMAX  = 99999;

  logic             clk = 1'b0;
  logic             rst;
  logic             game_start;
  logic             tick;
  logic [LANES-1:0] note_valid;
  logic [LANES-1:0] key_press;
  logic [31:0]      score;
  logic [3:0]       combo;
  logic [7:0]       accuracy;
  logic             judge_valid;
  logic [2:0]       judge_lane;
  logic [1:0]       judge_result;
  logic             overrun;

  int checks   = 0;
  int failures = 0;

  // Reference model: lane status 0 idle, 1 waiting for key, 2 judged but not yet reported.
  int         m_state [LANES];
  int         m_age   [LANES];
  logic [1:0] m_res   [LANES];
  int         m_score;
  int         m_combo;
  int         m_notes;
  int         m_hits;
  logic       m_overrun;
  int         since_tick;

  rhythm_judge_scorer dut (
    .clk          (clk),
    .rst          (rst),
    .game_start   (game_start),
    .tick         (tick),
    .note_valid   (note_valid),
    .key_press    (key_press),
    .score        (score),
    .combo        (combo),
    .accuracy     (accuracy),
    .judge_valid  (judge_valid),
    .judge_lane   (judge_lane),
    .judge_result (judge_result),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [LANES-1:0] n, input logic [LANES-1:0] k, input logic t);
    note_valid = n;
    key_press  = k;
    tick       = t;
    @(posedge clk);
    #1;
    note_valid = '0;
    key_press  = '0;
    tick       = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive('0, '0, 1'b0);
  endtask

  task automatic do_tick();
    drive('0, '0, 1'b1);
    idle(5);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_score"}, score, 32'd0);
    check({tag, "_combo"}, 32'(combo), 32'd0);
    check({tag, "_accuracy"}, 32'(accuracy), 32'd0);
    check({tag, "_judge_valid"}, 32'(judge_valid), 32'd0);
    check({tag, "_judge_lane"}, 32'(judge_lane), 32'd0);
    check({tag, "_judge_result"}, 32'(judge_result), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic wait_judge(input string tag);
    int n;
    n = 0;
    while (!judge_valid && n < 10) begin
      idle(1);
      n++;
    end
    check({tag, "_seen"}, 32'(judge_valid), 32'd1);
  endtask

  task automatic count_judges(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      idle(1);
      if (judge_valid) seen++;
    end
  endtask

  function automatic logic [7:0] exp_acc(input int hits, input int notes);
    int q;
    if (notes == 0) return 8'h00;
    q = hits * 100 / notes;
    if (q > 99) q = 99;
    return 8'((q / 10) * 16 + (q % 10));
  endfunction

  task automatic observe();
    int l;
    int st;
    if (judge_valid) begin
      l  = int'(judge_lane);
      st = (l < LANES) ? m_state[l] : -1;
      check("rnd_lane_awaiting", 32'(st), 32'd2);
      if (st == 2) begin
        check("rnd_result", 32'(judge_result), 32'(m_res[l]));
        m_state[l] = 0;
        m_notes++;
        if (m_res[l] != 2'b11) begin
          m_hits++;
          m_combo = (m_combo + 1 > 9) ? 9 : m_combo + 1;
          m_score = m_score + ((m_res[l] == 2'b01) ? PP : PG);
          if (m_score > SMAX) m_score = SMAX;
        end else begin
          m_combo = 0;
        end
      end
      check("rnd_score", score, 32'(m_score));
      check("rnd_combo", 32'(combo), 32'(m_combo));
    end
  endtask

  task automatic rand_step(input bit stim);
    logic [LANES-1:0] n;
    logic [LANES-1:0] k;
    logic             t;
    observe();
    n = '0;
    k = '0;
    t = (since_tick >= LANES + 2) && ($urandom_range(0, 2) == 0);
    if (stim) begin
      for (int i = 0; i < LANES; i++) begin
        if (m_state[i] == 0 && $urandom_range(0, 11) == 0) n[i] = 1'b1;
        else if (m_state[i] == 1 && $urandom_range(0, 59) == 0) n[i] = 1'b1;
        if (!n[i] && $urandom_range(0, 5) == 0) k[i] = 1'b1;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      case (m_state[i])
        0: if (n[i]) begin
             m_state[i] = 1;
             m_age[i]   = 0;
           end
        1: if (k[i]) begin
             m_state[i] = 2;
             m_res[i]   = (m_age[i] <= WP) ? 2'b01 : 2'b10;
           end else if (n[i]) begin
             m_state[i] = 2;
             m_res[i]   = 2'b11;
             m_overrun  = 1'b1;
           end else if (t) begin
             if (m_age[i] + 1 > WG) begin
               m_state[i] = 2;
               m_res[i]   = 2'b11;
             end else begin
               m_age[i] = m_age[i] + 1;
             end
           end
        default: if (n[i]) m_overrun = 1'b1;
      endcase
    end
    since_tick = t ? 1 : since_tick + 1;
    drive(n, k, t);
  endtask

  initial begin
    int seen;
    int left;

    rst        = 1'b1;
    game_start = 1'b0;
    tick       = 1'b0;
    note_valid = '0;
    key_press  = '0;
    idle(2);
    rst = 1'b0;
    check_cleared("reset");

    // Single PERFECT on lane 0, one tick after arrival.
    drive(4'b0001, '0, 1'b0);
    do_tick();
    drive('0, 4'b0001, 1'b0);
    check("perfect_not_same_cycle", 32'(judge_valid), 32'd0);
    wait_judge("perfect");
    check("perfect_lane", 32'(judge_lane), 32'd0);
    check("perfect_result", 32'(judge_result), 32'h1);
    check("perfect_score", score, 32'd100);
    check("perfect_combo", 32'(combo), 32'd1);
    idle(30);
    check("perfect_accuracy", 32'(accuracy), 32'h99);

    // GOOD on lane 1 after four ticks.
    drive(4'b0010, '0, 1'b0);
    repeat (4) do_tick();
    drive('0, 4'b0010, 1'b0);
    wait_judge("good");
    check("good_lane", 32'(judge_lane), 32'd1);
    check("good_result", 32'(judge_result), 32'h2);
    check("good_score", score, 32'd150);
    check("good_combo", 32'(combo), 32'd2);

    // Unanswered note on lane 2 expires on the seventh tick.
    drive(4'b0100, '0, 1'b0);
    repeat (6) do_tick();
    check("miss_not_early", 32'(judge_valid), 32'd0);
    drive('0, '0, 1'b1);
    wait_judge("miss");
    check("miss_lane", 32'(judge_lane), 32'd2);
    check("miss_result", 32'(judge_result), 32'h3);
    check("miss_score", score, 32'd150);
    check("miss_combo", 32'(combo), 32'd0);
    idle(30);
    check("miss_accuracy", 32'(accuracy), 32'h66);

    // Lanes 0 and 2 judged PERFECT together are reported on consecutive cycles.
    drive(4'b0101, '0, 1'b0);
    do_tick();
    drive('0, 4'b0101, 1'b0);
    wait_judge("dual_first");
    check("dual_first_lane", 32'(judge_lane), 32'd0);
    check("dual_first_score", score, 32'd250);
    idle(1);
    check("dual_second_valid", 32'(judge_valid), 32'd1);
    check("dual_second_lane", 32'(judge_lane), 32'd2);
    check("dual_second_result", 32'(judge_result), 32'h1);
    check("dual_score", score, 32'd350);
    check("dual_combo", 32'(combo), 32'd2);
    idle(70);
    check("dual_accuracy", 32'(accuracy), 32'h80);

    // Note re-arriving on a lane whose result is still waiting for the arbiter.
    drive(4'b1001, '0, 1'b0);
    drive('0, 4'b1001, 1'b0);
    drive(4'b1000, '0, 1'b0);
    check("ovr_first_valid", 32'(judge_valid), 32'd1);
    check("ovr_first_lane", 32'(judge_lane), 32'd0);
    check("ovr_flag", 32'(overrun), 32'd1);
    idle(1);
    check("ovr_second_lane", 32'(judge_lane), 32'd3);
    check("ovr_score", score, 32'd550);
    check("ovr_combo", 32'(combo), 32'd4);
    drive('0, 4'b1000, 1'b0);
    count_judges(10, seen);
    check("ovr_dropped_note_ignored", 32'(seen), 32'd0);
    idle(70);
    check("ovr_accuracy", 32'(accuracy), 32'h85);

    // Combo saturation, then score saturation.
    repeat (12) begin
      drive(4'b0001, '0, 1'b0);
      drive('0, 4'b0001, 1'b0);
      idle(1);
    end
    check("combo_sat", 32'(combo), 32'd9);
    check("combo_sat_score", score, 32'd1750);
    repeat (1000) begin
      drive(4'b0001, '0, 1'b0);
      drive('0, 4'b0001, 1'b0);
      idle(1);
    end
    check("score_sat", score, 32'(SMAX));
    check("score_sat_combo", 32'(combo), 32'd9);
    check("score_sat_overrun_sticky", 32'(overrun), 32'd1);

    // game_start while the divider is mid-run.
    idle(5);
    game_start = 1'b1;
    idle(1);
    game_start = 1'b0;
    check_cleared("game_start");
    idle(40);
    check("game_start_no_stale_acc", 32'(accuracy), 32'h00);

    // rst held two cycles with a result pending and overrun raised.
    drive(4'b0001, '0, 1'b0);
    drive('0, 4'b0001, 1'b0);
    idle(1);
    check("pre_rst_score", score, 32'd100);
    drive(4'b0010, '0, 1'b0);
    drive(4'b0010, '0, 1'b0);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_cleared("mid_rst");
    drive('0, 4'b0010, 1'b0);
    count_judges(10, seen);
    check("mid_rst_lane_idle", 32'(seen), 32'd0);

    // Randomized run against the reference model.
    for (int i = 0; i < LANES; i++) begin
      m_state[i] = 0;
      m_age[i]   = 0;
      m_res[i]   = 2'b00;
    end
    m_score    = 0;
    m_combo    = 0;
    m_notes    = 0;
    m_hits     = 0;
    m_overrun  = 1'b0;
    since_tick = LANES + 2;
    for (int c = 0; c < 3000; c++) rand_step(1'b1);
    for (int c = 0; c < 200; c++) rand_step(1'b0);
    left = 0;
    for (int i = 0; i < LANES; i++) if (m_state[i] != 0) left++;
    check("rnd_drained", 32'(left), 32'd0);
    idle(70);
    check("rnd_accuracy", 32'(accuracy), 32'(exp_acc(m_hits, m_notes)));
    check("rnd_final_score", score, 32'(m_score));
    check("rnd_final_combo", 32'(combo), 32'(m_combo));
    check("rnd_overrun", 32'(overrun), 32'(m_overrun));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
